// File: rtl/fdivsqrt_issue_queue_pkg.sv
// Shared widths, encodings and payload types for the FP div/sqrt issue queue.
package fdivsqrt_issue_queue_pkg;

  localparam int PHY_REG_ADDR_WIDTH = 6;
  localparam int ROB_INDEX_WIDTH    = 4;
  localparam int XLEN               = 64;
  localparam int FUNC_SEL_WIDTH     = 5;
  localparam int FFLAGS_WIDTH       = 5;

  localparam logic [1:0] FMT_S  = 2'b00;
  localparam logic [2:0] RM_DYN = 3'b111;

  typedef struct packed {
    logic [PHY_REG_ADDR_WIDTH-1:0] prd;
    logic [ROB_INDEX_WIDTH-1:0]    rob;
    logic [XLEN-1:0]               op1;
    logic [XLEN-1:0]               op2;
    logic [FUNC_SEL_WIDTH-1:0]     func_sel;
    logic                          divsqrt;
    logic [2:0]                    rm;
    logic [1:0]                    fmt;
  } iq_entry_t;

  typedef struct packed {
    logic [PHY_REG_ADDR_WIDTH-1:0] prd;
    logic [ROB_INDEX_WIDTH-1:0]    rob;
    logic [XLEN-1:0]               data;
    logic [FFLAGS_WIDTH-1:0]       fflags;
  } wb_entry_t;

endpackage

// File: rtl/fdivsqrt_issue_queue_if.sv
// Request/writeback link between the issue queue (master) and the div/sqrt unit (slave).
interface fdivsqrt_issue_queue_if;
  import fdivsqrt_issue_queue_pkg::*;

  logic                          req_valid;
  logic                          req_ready;
  logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr;
  logic [XLEN-1:0]               oprd1;
  logic [XLEN-1:0]               oprd2;
  logic [ROB_INDEX_WIDTH-1:0]    rob_index;
  logic [FUNC_SEL_WIDTH-1:0]     func_sel;
  logic                          divsqrt;
  logic [2:0]                    rounding_mode;
  logic [2:0]                    fcsr_frm;
  logic [1:0]                    fmt;

  logic                          wrb_valid;
  logic [PHY_REG_ADDR_WIDTH-1:0] wrb_prd_addr;
  logic [ROB_INDEX_WIDTH-1:0]    wrb_rob_index;
  logic [XLEN-1:0]               wrb_data;
  logic [FFLAGS_WIDTH-1:0]       fflags;

  modport master (
    output req_valid, prd_addr, oprd1, oprd2, rob_index, func_sel, divsqrt,
           rounding_mode, fcsr_frm, fmt,
    input  req_ready, wrb_valid, wrb_prd_addr, wrb_rob_index, wrb_data, fflags
  );

  modport slave (
    input  req_valid, prd_addr, oprd1, oprd2, rob_index, func_sel, divsqrt,
           rounding_mode, fcsr_frm, fmt,
    output req_ready, wrb_valid, wrb_prd_addr, wrb_rob_index, wrb_data, fflags
  );

endinterface

// File: rtl/fdivsqrt_iq_fifo.sv
// Generic DEPTH x W synchronous FIFO with flush; head word is read combinationally.
module fdivsqrt_iq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_en) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/fdivsqrt_issue_queue.sv
// In-order issue queue for FDIV/FSQRT: one op outstanding, one-entry result buffer
// absorbing the unit's non-stallable writeback pulse.
module fdivsqrt_issue_queue
  import fdivsqrt_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trap,
  input  logic                          disp_enq_valid_i,
  output logic                          disp_enq_ready_o,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] disp_prd_addr_i,
  input  logic [ROB_INDEX_WIDTH-1:0]    disp_rob_index_i,
  input  logic [XLEN-1:0]               disp_oprd1_i,
  input  logic [XLEN-1:0]               disp_oprd2_i,
  input  logic [FUNC_SEL_WIDTH-1:0]     disp_func_sel_i,
  input  logic                          disp_divsqrt_i,
  input  logic [2:0]                    disp_rounding_mode_i,
  input  logic [1:0]                    disp_fmt_i,
  input  logic [2:0]                    fcsr_frm_i,
  fdivsqrt_issue_queue_if.master        fu,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [PHY_REG_ADDR_WIDTH-1:0] wb_prd_addr_o,
  output logic [ROB_INDEX_WIDTH-1:0]    wb_rob_index_o,
  output logic [XLEN-1:0]               wb_data_o,
  output logic [FFLAGS_WIDTH-1:0]       wb_fflags_o,
  output logic                          busy_o
);

  localparam int CW = $clog2(DEPTH+1);

  iq_entry_t     enq_entry, head;
  logic [$bits(iq_entry_t)-1:0] fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          push, req_valid, issue;

  logic          outstanding_q, outstanding_d;
  logic          rbuf_valid_q, rbuf_valid_d;
  wb_entry_t     rbuf_q, rbuf_d;

  assign enq_entry = '{prd: disp_prd_addr_i, rob: disp_rob_index_i,
                       op1: disp_oprd1_i, op2: disp_oprd2_i,
                       func_sel: disp_func_sel_i, divsqrt: disp_divsqrt_i,
                       rm: disp_rounding_mode_i, fmt: disp_fmt_i};

  assign push = disp_enq_valid_i & ~fifo_full & ~trap;

  fdivsqrt_iq_fifo #(.DEPTH(DEPTH), .W($bits(iq_entry_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (trap),
    .push  (push),
    .wdata (enq_entry),
    .pop   (issue),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = iq_entry_t'(fifo_rdata);

  // Holding the result buffer blocks issue unless it drains this cycle, so a
  // new writeback pulse always finds room.
  assign req_valid = (fifo_count != '0) & ~outstanding_q & (~rbuf_valid_q | wb_ready_i) & ~trap;
  assign issue     = req_valid & fu.req_ready;

  assign fu.req_valid     = req_valid;
  assign fu.prd_addr      = head.prd;
  assign fu.oprd1         = head.op1;
  assign fu.oprd2         = head.op2;
  assign fu.rob_index     = head.rob;
  assign fu.func_sel      = head.func_sel;
  assign fu.divsqrt       = head.divsqrt;
  assign fu.rounding_mode = head.rm;
  assign fu.fcsr_frm      = fcsr_frm_i;
  assign fu.fmt           = head.fmt;

  assign disp_enq_ready_o = ~fifo_full;

  always_comb begin
    outstanding_d = outstanding_q;
    rbuf_valid_d  = rbuf_valid_q;
    rbuf_d        = rbuf_q;
    if (trap) begin
      outstanding_d = 1'b0;
      rbuf_valid_d  = 1'b0;
    end else begin
      if (fu.wrb_valid) outstanding_d = 1'b0;
      if (issue)        outstanding_d = 1'b1;
      // A load coincident with a drain keeps the buffer full with the new result.
      if (fu.wrb_valid) begin
        rbuf_valid_d = 1'b1;
        rbuf_d       = '{prd: fu.wrb_prd_addr, rob: fu.wrb_rob_index,
                         data: fu.wrb_data, fflags: fu.fflags};
      end else if (rbuf_valid_q && wb_ready_i) begin
        rbuf_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= 1'b0;
      rbuf_valid_q  <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      rbuf_valid_q  <= rbuf_valid_d;
    end
  end

  always_ff @(posedge clk) rbuf_q <= rbuf_d;

  assign wb_valid_o     = rbuf_valid_q;
  assign wb_prd_addr_o  = rbuf_q.prd;
  assign wb_rob_index_o = rbuf_q.rob;
  assign wb_data_o      = rbuf_q.data;
  assign wb_fflags_o    = rbuf_q.fflags;

  assign busy_o = ~fifo_empty | outstanding_q | rbuf_valid_q;

endmodule

// File: tb/tb_fdivsqrt_issue_queue.sv
// Directed bench: hand-written multi-cycle sequences plus a table-driven streaming run.
module tb_fdivsqrt_issue_queue;
  import fdivsqrt_issue_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, trap;
  logic        disp_enq_valid_i, disp_enq_ready_o;
  logic [5:0]  disp_prd_addr_i;
  logic [3:0]  disp_rob_index_i;
  logic [63:0] disp_oprd1_i, disp_oprd2_i;
  logic [4:0]  disp_func_sel_i;
  logic        disp_divsqrt_i;
  logic [2:0]  disp_rounding_mode_i;
  logic [1:0]  disp_fmt_i;
  logic [2:0]  fcsr_frm_i;
  logic        wb_valid_o, wb_ready_i;
  logic [5:0]  wb_prd_addr_o;
  logic [3:0]  wb_rob_index_o;
  logic [63:0] wb_data_o;
  logic [4:0]  wb_fflags_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  bit model_out = 1'b0;
  bit allow_spurious = 1'b0;

  fdivsqrt_issue_queue_if fu ();

  fdivsqrt_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .trap(trap),
    .disp_enq_valid_i(disp_enq_valid_i), .disp_enq_ready_o(disp_enq_ready_o),
    .disp_prd_addr_i(disp_prd_addr_i), .disp_rob_index_i(disp_rob_index_i),
    .disp_oprd1_i(disp_oprd1_i), .disp_oprd2_i(disp_oprd2_i),
    .disp_func_sel_i(disp_func_sel_i), .disp_divsqrt_i(disp_divsqrt_i),
    .disp_rounding_mode_i(disp_rounding_mode_i), .disp_fmt_i(disp_fmt_i),
    .fcsr_frm_i(fcsr_frm_i), .fu(fu.master),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_prd_addr_o(wb_prd_addr_o), .wb_rob_index_o(wb_rob_index_o),
    .wb_data_o(wb_data_o), .wb_fflags_o(wb_fflags_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rob;
    logic [5:0]  prd;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        ds;
    logic [63:0] exp_data;
    logic [4:0]  exp_ff;
  } vec_t;

  vec_t tbl [10];

  // Stand-in for the div/sqrt datapath.
  function automatic logic [63:0] unit_data(input logic [63:0] a, input logic [63:0] b, input logic ds);
    return ds ? ~a : a + b;
  endfunction

  function automatic logic [4:0] unit_ff(input logic [63:0] a, input logic ds);
    return a[4:0] ^ {ds, 4'b0000};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic enq(input logic [3:0] rob, input logic [5:0] prd, input logic [63:0] op1, input logic ds);
    disp_rob_index_i = rob;
    disp_prd_addr_i  = prd;
    disp_oprd1_i     = op1;
    disp_oprd2_i     = 64'd100;
    disp_divsqrt_i   = ds;
    disp_enq_valid_i = 1'b1;
    check("enq_ready", disp_enq_ready_o, 1);
    tick();
    disp_enq_valid_i = 1'b0;
  endtask

  task automatic serve(input logic [3:0] exp_rob);
    for (int i = 0; i < 50 && fu.req_valid !== 1'b1; i++) tick();
    check("req_valid_seen", fu.req_valid, 1);
    check("issue_rob", fu.rob_index, exp_rob);
    fu.req_ready = 1'b1;
    tick();
    fu.req_ready = 1'b0;
    check("one_issue", fu.req_valid, 0);
  endtask

  task automatic respond(input logic [3:0] rob, input logic [5:0] prd, input logic [63:0] data, input logic [4:0] ff);
    fu.wrb_rob_index = rob;
    fu.wrb_prd_addr  = prd;
    fu.wrb_data      = data;
    fu.fflags        = ff;
    fu.wrb_valid     = 1'b1;
    tick();
    fu.wrb_valid     = 1'b0;
  endtask

  // Independent outstanding tracker: a pulse with nothing outstanding is a protocol error.
  always @(posedge clk) begin
    if (rst || trap) model_out = 1'b0;
    else begin
      if (fu.wrb_valid === 1'b1) begin
        checks++;
        if (!model_out && !allow_spurious) begin
          errors++;
          $display("FAIL resp_without_outstanding: got 0 expected 1");
        end
        model_out = 1'b0;
      end
      if (fu.req_valid === 1'b1 && fu.req_ready === 1'b1) model_out = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int in_i, out_i, lat;
    bit ubusy;
    logic [3:0]  cap_rob;
    logic [5:0]  cap_prd;
    logic [63:0] cap_op1, cap_op2;
    logic        cap_ds;

    tbl[0] = '{4'd1,  6'd20, 64'd3,  64'd100, 1'b0, 64'd103,               5'h03};
    tbl[1] = '{4'd2,  6'd21, 64'd4,  64'd100, 1'b1, 64'hFFFFFFFFFFFFFFFB, 5'h14};
    tbl[2] = '{4'd3,  6'd22, 64'd5,  64'd100, 1'b0, 64'd105,               5'h05};
    tbl[3] = '{4'd4,  6'd23, 64'd6,  64'd100, 1'b1, 64'hFFFFFFFFFFFFFFF9, 5'h16};
    tbl[4] = '{4'd5,  6'd24, 64'd7,  64'd100, 1'b0, 64'd107,               5'h07};
    tbl[5] = '{4'd6,  6'd25, 64'd8,  64'd100, 1'b1, 64'hFFFFFFFFFFFFFFF7, 5'h18};
    tbl[6] = '{4'd7,  6'd26, 64'd9,  64'd100, 1'b0, 64'd109,               5'h09};
    tbl[7] = '{4'd8,  6'd27, 64'd10, 64'd100, 1'b1, 64'hFFFFFFFFFFFFFFF5, 5'h1A};
    tbl[8] = '{4'd9,  6'd28, 64'd11, 64'd100, 1'b0, 64'd111,               5'h0B};
    tbl[9] = '{4'd10, 6'd29, 64'd12, 64'd100, 1'b1, 64'hFFFFFFFFFFFFFFF3, 5'h1C};

    rst = 1'b1; trap = 1'b0;
    disp_enq_valid_i = 1'b0; disp_prd_addr_i = '0; disp_rob_index_i = '0;
    disp_oprd1_i = '0; disp_oprd2_i = '0; disp_func_sel_i = 5'h0C; disp_divsqrt_i = 1'b0;
    disp_rounding_mode_i = 3'b111; disp_fmt_i = 2'b01; fcsr_frm_i = 3'b010;
    wb_ready_i = 1'b0;
    fu.req_ready = 1'b0; fu.wrb_valid = 1'b0; fu.wrb_prd_addr = '0;
    fu.wrb_rob_index = '0; fu.wrb_data = '0; fu.fflags = '0;

    tick(); tick();
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_req_valid", fu.req_valid, 0);
    check("rst_enq_ready", disp_enq_ready_o, 1);
    check("rst_busy", busy_o, 0);
    rst = 1'b0;

    // 1: single div through an idle unit
    fu.req_ready = 1'b1;
    disp_rob_index_i = 4'd3; disp_prd_addr_i = 6'd9;
    disp_oprd1_i = 64'h40; disp_oprd2_i = 64'h8; disp_enq_valid_i = 1'b1;
    #1 check("t1_no_bypass", fu.req_valid, 0);
    tick();
    disp_enq_valid_i = 1'b0;
    check("t1_req_valid", fu.req_valid, 1);
    check("t1_rob", fu.rob_index, 3);
    check("t1_prd", fu.prd_addr, 9);
    check("t1_op1", fu.oprd1, 64'h40);
    check("t1_rm_dyn_passthru", fu.rounding_mode, 3'b111);
    check("t1_frm", fu.fcsr_frm, 3'b010);
    check("t1_fmt", fu.fmt, 2'b01);
    check("t1_func_sel", fu.func_sel, 5'h0C);
    tick();
    fu.req_ready = 1'b0;
    check("t1_outstanding_blocks", fu.req_valid, 0);
    check("t1_busy", busy_o, 1);
    repeat (9) tick();
    respond(4'd3, 6'd9, 64'hDEAD, 5'h01);
    check("t1_wb_valid", wb_valid_o, 1);
    check("t1_wb_rob", wb_rob_index_o, 3);
    check("t1_wb_prd", wb_prd_addr_o, 9);
    check("t1_wb_data", wb_data_o, 64'hDEAD);
    check("t1_wb_ff", wb_fflags_o, 5'h01);
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    check("t1_wb_drained", wb_valid_o, 0);
    check("t1_idle", busy_o, 0);

    // 2: fill to DEPTH, hold a fifth, then issue strictly one per response
    for (int k = 0; k < 4; k++) enq(4'(4 + k), 6'(10 + k), 64'(k), 1'b0);
    check("t2_full", disp_enq_ready_o, 0);
    check("t2_req_valid", fu.req_valid, 1);
    disp_rob_index_i = 4'd8; disp_prd_addr_i = 6'd14; disp_oprd1_i = 64'd4;
    disp_enq_valid_i = 1'b1;
    tick();
    check("t2_fifth_held", disp_enq_ready_o, 0);
    check("t2_head_stable", fu.rob_index, 4);
    fu.req_ready = 1'b1;
    tick();
    fu.req_ready = 1'b0;
    check("t2_single_issue", fu.req_valid, 0);
    check("t2_room", disp_enq_ready_o, 1);
    tick();
    disp_enq_valid_i = 1'b0;
    check("t2_fifth_taken", disp_enq_ready_o, 0);
    respond(4'd4, 6'd10, 64'h100, 5'd0);
    check("t2_wb_rob0", wb_rob_index_o, 4);
    wb_ready_i = 1'b1;
    tick();
    for (int k = 1; k < 5; k++) begin
      serve(4'(4 + k));
      respond(4'(4 + k), 6'(10 + k), 64'h100 + 64'(k), 5'(k));
      check("t2_wb_valid", wb_valid_o, 1);
      check("t2_wb_rob", wb_rob_index_o, 4 + k);
      check("t2_wb_prd", wb_prd_addr_o, 10 + k);
      tick();
    end
    wb_ready_i = 1'b0;
    check("t2_idle", busy_o, 0);

    // 3: full result buffer with wb_ready low blocks issue
    enq(4'd9, 6'd20, 64'd1, 1'b0);
    enq(4'd10, 6'd21, 64'd2, 1'b0);
    serve(4'd9);
    respond(4'd9, 6'd20, 64'h9999, 5'd0);
    check("t3_rbuf_full", wb_valid_o, 1);
    check("t3_blocked", fu.req_valid, 0);
    repeat (3) tick();
    check("t3_still_blocked", fu.req_valid, 0);
    check("t3_rbuf_held", wb_rob_index_o, 9);
    wb_ready_i = 1'b1; fu.req_ready = 1'b1;
    #1 check("t3_unblocked", fu.req_valid, 1);
    check("t3_next_rob", fu.rob_index, 10);
    tick();
    wb_ready_i = 1'b0; fu.req_ready = 1'b0;
    check("t3_drained", wb_valid_o, 0);
    check("t3_issued", fu.req_valid, 0);
    check("t3_busy", busy_o, 1);
    respond(4'd10, 6'd21, 64'hAAAA, 5'd2);
    check("t3_wb_rob", wb_rob_index_o, 10);

    // 4a: trap with ops queued and one outstanding
    enq(4'd11, 6'd30, 64'd1, 1'b0);
    enq(4'd12, 6'd31, 64'd2, 1'b0);
    enq(4'd13, 6'd32, 64'd3, 1'b0);
    wb_ready_i = 1'b1; fu.req_ready = 1'b1;
    tick();
    wb_ready_i = 1'b0; fu.req_ready = 1'b0;
    check("t4_pre_busy", busy_o, 1);
    trap = 1'b1;
    tick();
    trap = 1'b0;
    check("t4_wb_valid", wb_valid_o, 0);
    check("t4_req_valid", fu.req_valid, 0);
    check("t4_enq_ready", disp_enq_ready_o, 1);
    check("t4_busy", busy_o, 0);

    // 4b: trap with full result buffer; coincident enqueue and issue are dropped
    enq(4'd14, 6'd33, 64'd4, 1'b0);
    serve(4'd14);
    respond(4'd14, 6'd33, 64'h1414, 5'd0);
    enq(4'd15, 6'd34, 64'd5, 1'b0);
    wb_ready_i = 1'b1; fu.req_ready = 1'b1;
    #1 check("t4b_req_before_trap", fu.req_valid, 1);
    trap = 1'b1;
    disp_rob_index_i = 4'd0; disp_enq_valid_i = 1'b1;
    #1 check("t4b_trap_gates_req", fu.req_valid, 0);
    tick();
    trap = 1'b0; disp_enq_valid_i = 1'b0; wb_ready_i = 1'b0; fu.req_ready = 1'b0;
    check("t4b_wb_valid", wb_valid_o, 0);
    check("t4b_busy", busy_o, 0);
    tick();
    check("t4b_enq_dropped", busy_o, 0);
    check("t4b_no_req", fu.req_valid, 0);

    // 5: new result loads while the old one drains
    enq(4'd1, 6'd2, 64'd6, 1'b0);
    serve(4'd1);
    respond(4'd1, 6'd2, 64'hAAAA, 5'd3);
    tick();
    allow_spurious = 1'b1;
    fu.wrb_rob_index = 4'd2; fu.wrb_prd_addr = 6'd3;
    fu.wrb_data = 64'hBBBB; fu.fflags = 5'd4; fu.wrb_valid = 1'b1;
    wb_ready_i = 1'b1;
    #1 check("t5_old_accepted", wb_data_o, 64'hAAAA);
    tick();
    fu.wrb_valid = 1'b0; wb_ready_i = 1'b0; allow_spurious = 1'b0;
    check("t5_valid_kept", wb_valid_o, 1);
    check("t5_new_data", wb_data_o, 64'hBBBB);
    check("t5_new_rob", wb_rob_index_o, 2);
    tick();
    check("t5_still_new", wb_data_o, 64'hBBBB);
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    check("t5_drained", wb_valid_o, 0);
    check("t5_idle", busy_o, 0);

    // 6: stream ten ops through DEPTH=4 so both pointers wrap
    in_i = 0; out_i = 0; lat = 0; ubusy = 1'b0;
    cap_rob = '0; cap_prd = '0; cap_op1 = '0; cap_op2 = '0; cap_ds = 1'b0;
    wb_ready_i = 1'b1;
    for (int cyc = 0; cyc < 400 && out_i < 10; cyc++) begin
      if (wb_valid_o === 1'b1) begin
        if (out_i < 10) begin
          check("t6_rob", wb_rob_index_o, tbl[out_i].rob);
          check("t6_prd", wb_prd_addr_o, tbl[out_i].prd);
          check("t6_data", wb_data_o, tbl[out_i].exp_data);
          check("t6_fflags", wb_fflags_o, tbl[out_i].exp_ff);
        end
        out_i++;
      end
      fu.wrb_valid = 1'b0;
      if (ubusy) begin
        if (lat == 0) begin
          fu.wrb_rob_index = cap_rob;
          fu.wrb_prd_addr  = cap_prd;
          fu.wrb_data      = unit_data(cap_op1, cap_op2, cap_ds);
          fu.fflags        = unit_ff(cap_op1, cap_ds);
          fu.wrb_valid     = 1'b1;
          ubusy = 1'b0;
        end else lat--;
      end
      fu.req_ready = !ubusy;
      if (fu.req_valid === 1'b1 && fu.req_ready === 1'b1) begin
        cap_rob = fu.rob_index; cap_prd = fu.prd_addr;
        cap_op1 = fu.oprd1; cap_op2 = fu.oprd2; cap_ds = fu.divsqrt;
        ubusy = 1'b1; lat = 3;
      end
      if (in_i < 10) begin
        disp_rob_index_i = tbl[in_i].rob;
        disp_prd_addr_i  = tbl[in_i].prd;
        disp_oprd1_i     = tbl[in_i].op1;
        disp_oprd2_i     = tbl[in_i].op2;
        disp_divsqrt_i   = tbl[in_i].ds;
        disp_enq_valid_i = 1'b1;
        if (disp_enq_ready_o === 1'b1) in_i++;
      end else disp_enq_valid_i = 1'b0;
      tick();
    end
    disp_enq_valid_i = 1'b0; fu.req_ready = 1'b0; fu.wrb_valid = 1'b0;
    check("t6_all_results", out_i, 10);
    tick();
    wb_ready_i = 1'b0;
    check("t6_idle", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
